// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong score keeper: FSM state codes, BCD width,
// and a binary-to-BCD constant function for building the winning-score compare values.
package pong_pkg;

  localparam int BCD_W = 8;

  localparam logic [1:0] SERVE = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] WON   = 2'd2;

  // Values 0..99 map to {tens,ones}.
  function automatic logic [BCD_W-1:0] bin_to_bcd(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'((v / 10) % 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD up-counter; the value updates on the edge after inc or clr.
// clr takes priority over inc, and there is no backpressure.
module bcd_counter_2d
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] bcd
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd <= '0;
    end else if (clr) begin
      bcd <= '0;
    end else if (inc) begin
      if (bcd[3:0] == 4'd9) begin
        bcd <= {bcd[7:4] + 4'd1, 4'd0};
      end else begin
        bcd <= {bcd[7:4], bcd[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/pong_score_keeper.sv
// Turns ball-miss edges into BCD scores, win flags and a serve hold-off; all outputs are registered
// and react one cycle after the miss edge. pause freezes scoring and the hold-off; reset_game clears everything.
module pong_score_keeper
  import pong_pkg::*;
#(
  parameter int MAX_SCORE       = 9,
  parameter int SERVE_DELAY_CYC = 50_000_000,
  parameter int CNT_W           = 26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reset_game,
  input  logic             pause,
  input  logic             left_miss,
  input  logic             right_miss,
  output logic [BCD_W-1:0] left_bcd,
  output logic [BCD_W-1:0] right_bcd,
  output logic             left_score_max,
  output logic             right_score_max,
  output logic             serve_hold,
  output logic             serve_dir,
  output logic             point_tick
);

  // A score equal to PRE_BCD becomes MAX_SCORE on its next point.
  localparam logic [BCD_W-1:0] MAX_BCD  = bin_to_bcd(MAX_SCORE);
  localparam logic [BCD_W-1:0] PRE_BCD  = bin_to_bcd(MAX_SCORE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY_CYC - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             left_q;
  logic             right_q;
  logic             left_rise;
  logic             right_rise;
  logic             play_ev;
  logic             left_pt;
  logic             right_pt;
  logic             both_miss;
  logic             left_max_nxt;
  logic             right_max_nxt;
  logic             dir_nxt;
  logic             tick_nxt;

  assign left_rise  = left_miss & ~left_q;
  assign right_rise = right_miss & ~right_q;

  // right_miss means the left player scored, and vice versa.
  assign play_ev   = (state == PLAY) && !pause && !reset_game;
  assign left_pt   = play_ev && right_rise && !left_rise;
  assign right_pt  = play_ev && left_rise && !right_rise;
  assign both_miss = play_ev && left_rise && right_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SERVE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (reset_game) begin
      state_nxt = SERVE;
    end else begin
      case (state)
        SERVE: if (!pause && cnt == CNT_LAST) state_nxt = PLAY;
        PLAY: begin
          if (both_miss) begin
            state_nxt = SERVE;
          end else if (left_pt) begin
            state_nxt = (left_bcd == PRE_BCD) ? WON : SERVE;
          end else if (right_pt) begin
            state_nxt = (right_bcd == PRE_BCD) ? WON : SERVE;
          end
        end
        WON:     state_nxt = WON;
        default: state_nxt = SERVE;
      endcase
    end
  end

  always_comb begin
    cnt_nxt       = '0;
    tick_nxt      = left_pt | right_pt;
    dir_nxt       = serve_dir;
    left_max_nxt  = left_score_max;
    right_max_nxt = right_score_max;
    if (reset_game) begin
      dir_nxt       = 1'b0;
      left_max_nxt  = 1'b0;
      right_max_nxt = 1'b0;
    end else begin
      if (state == SERVE) begin
        if (pause) begin
          cnt_nxt = cnt;
        end else if (cnt != CNT_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      // Serve goes toward the player who just conceded.
      if (left_pt) begin
        dir_nxt      = 1'b1;
        left_max_nxt = (left_bcd == PRE_BCD);
      end else if (right_pt) begin
        dir_nxt       = 1'b0;
        right_max_nxt = (right_bcd == PRE_BCD);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt             <= '0;
      left_q          <= 1'b0;
      right_q         <= 1'b0;
      left_score_max  <= 1'b0;
      right_score_max <= 1'b0;
      serve_hold      <= 1'b1;
      serve_dir       <= 1'b0;
      point_tick      <= 1'b0;
    end else begin
      cnt             <= cnt_nxt;
      left_q          <= left_miss;
      right_q         <= right_miss;
      left_score_max  <= left_max_nxt;
      right_score_max <= right_max_nxt;
      serve_hold      <= (state_nxt != PLAY);
      serve_dir       <= dir_nxt;
      point_tick      <= tick_nxt;
    end
  end

  bcd_counter_2d u_left_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (reset_game),
    .inc     (left_pt),
    .bcd     (left_bcd)
  );

  bcd_counter_2d u_right_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (reset_game),
    .inc     (right_pt),
    .bcd     (right_bcd)
  );

  // MAX_BCD documents what the registered flags track; it must match bin_to_bcd(MAX_SCORE).
  if (MAX_BCD == '0) begin : g_bad_max
    $error("MAX_SCORE must be in 1..99");
  end

endmodule

// File: tb/tb_pong_score_keeper.sv
// Two score keepers (win at 3 and at 12) driven with shared directed and random stimulus,
// each checked every cycle against a point-counting reference model through an expectation queue.
module tb_pong_score_keeper;

  localparam int DELAY = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, reset_game, pause, left_miss, right_miss;
  logic [7:0] l_bcd [2];
  logic [7:0] r_bcd [2];
  logic l_max [2], r_max [2], hold [2], dir [2], tick [2];

  pong_score_keeper #(.MAX_SCORE(3), .SERVE_DELAY_CYC(DELAY), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .reset_game(reset_game), .pause(pause),
    .left_miss(left_miss), .right_miss(right_miss),
    .left_bcd(l_bcd[0]), .right_bcd(r_bcd[0]), .left_score_max(l_max[0]),
    .right_score_max(r_max[0]), .serve_hold(hold[0]), .serve_dir(dir[0]), .point_tick(tick[0])
  );

  pong_score_keeper #(.MAX_SCORE(12), .SERVE_DELAY_CYC(DELAY), .CNT_W(3)) u_dut12 (
    .clk(clk), .reset_n(reset_n), .reset_game(reset_game), .pause(pause),
    .left_miss(left_miss), .right_miss(right_miss),
    .left_bcd(l_bcd[1]), .right_bcd(r_bcd[1]), .left_score_max(l_max[1]),
    .right_score_max(r_max[1]), .serve_hold(hold[1]), .serve_dir(dir[1]), .point_tick(tick[1])
  );

  typedef struct {
    logic [7:0] lb;
    logic [7:0] rb;
    logic lm, rm, hold, dir, tick;
  } snap_t;

  snap_t exp_q0[$];
  snap_t exp_q1[$];

  int checks = 0;
  int errors = 0;

  // Reference model: whole-number scores, a phase (0 serve, 1 play, 2 won) and hold-off cycles elapsed.
  int maxs [2] = '{3, 12};
  int ls [2], rs [2], ph [2], held [2];
  bit dir_m [2], tick_m [2];
  bit lprev, rprev;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  always @(posedge clk) begin : model
    bit lr, rr;
    snap_t s;
    lr = left_miss && !lprev;
    rr = right_miss && !rprev;
    for (int i = 0; i < 2; i++) begin
      tick_m[i] = 1'b0;
      if (!reset_n || reset_game) begin
        ls[i] = 0; rs[i] = 0; ph[i] = 0; held[i] = 0; dir_m[i] = 1'b0;
      end else if (ph[i] == 0) begin
        if (!pause) begin
          if (held[i] == DELAY - 1) begin
            ph[i] = 1; held[i] = 0;
          end else begin
            held[i]++;
          end
        end
      end else if (ph[i] == 1 && !pause && (lr || rr)) begin
        if (lr && rr) begin
          ph[i] = 0;
        end else begin
          if (rr) begin ls[i]++; dir_m[i] = 1'b1; end
          else    begin rs[i]++; dir_m[i] = 1'b0; end
          tick_m[i] = 1'b1;
          ph[i] = (ls[i] == maxs[i] || rs[i] == maxs[i]) ? 2 : 0;
        end
      end
      s.lb = to_bcd(ls[i]);
      s.rb = to_bcd(rs[i]);
      s.lm = (ls[i] == maxs[i]);
      s.rm = (rs[i] == maxs[i]);
      s.hold = (ph[i] != 1);
      s.dir = dir_m[i];
      s.tick = tick_m[i];
      if (i == 0) exp_q0.push_back(s);
      else        exp_q1.push_back(s);
    end
    lprev = reset_n ? left_miss : 1'b0;
    rprev = reset_n ? right_miss : 1'b0;
  end

  task automatic chk(input string nm, input int u, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s at %0t: got %0h, expected %0h", u, nm, $time, act, exp);
    end
  endtask

  task automatic compare(input int u, input snap_t s);
    chk("left_bcd", u, l_bcd[u], s.lb);
    chk("right_bcd", u, r_bcd[u], s.rb);
    chk("left_score_max", u, 8'(l_max[u]), 8'(s.lm));
    chk("right_score_max", u, 8'(r_max[u]), 8'(s.rm));
    chk("serve_hold", u, 8'(hold[u]), 8'(s.hold));
    chk("serve_dir", u, 8'(dir[u]), 8'(s.dir));
    chk("point_tick", u, 8'(tick[u]), 8'(s.tick));
  endtask

  always @(negedge clk) begin : monitor
    if (exp_q0.size() > 0) compare(0, exp_q0.pop_front());
    if (exp_q1.size() > 0) compare(1, exp_q1.pop_front());
  end

  task automatic step(input bit rg, input bit p, input bit lm, input bit rm, input int n);
    reset_game = rg; pause = p; left_miss = lm; right_miss = rm;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic left_point();
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, DELAY + 2);
  endtask

  task automatic right_point();
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, DELAY + 2);
  endtask

  initial begin
    reset_n = 1'b0; reset_game = 1'b0; pause = 1'b0; left_miss = 1'b0; right_miss = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    step(0, 0, 0, 0, DELAY + 4);

    // Three left points win the MAX=3 unit; later misses must not move it.
    repeat (5) left_point();
    right_point();
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, DELAY + 2);

    // Simultaneous misses, then right_miss held from SERVE into PLAY.
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 1, DELAY + 4);
    step(0, 0, 0, 0, DELAY + 2);

    // Pause mid hold-off, then a rise hidden under pause in PLAY.
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 2);
    step(0, 1, 0, 0, 10);
    step(0, 0, 0, 0, DELAY + 2);
    step(0, 1, 0, 1, 3);
    step(0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 3);

    // reset_n during a hold-off.
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    reset_n = 1'b0;
    step(0, 0, 0, 0, 2);
    reset_n = 1'b1;
    step(0, 0, 0, 0, DELAY + 3);

    // BCD carry on the MAX=12 unit.
    repeat (12) left_point();
    repeat (2) right_point();

    // reset_game together with a miss rise in PLAY.
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, DELAY + 2);
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 0, DELAY + 3);

    repeat (4000) begin
      reset_n    = ($urandom_range(0, 999) >= 2);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if ($urandom_range(0, 11) == 0) left_miss = ~left_miss;
      if ($urandom_range(0, 11) == 0) right_miss = ~right_miss;
      reset_game = ($urandom_range(0, 599) == 0);
      @(negedge clk);
      #1;
    end
    reset_n = 1'b1;
    step(0, 0, 0, 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
